// File: rtl/imm_encode_if.sv
// rtl/imm_encode_if.sv - handshake bundle for the immediate encoder: input template side and encoded-word side.
interface imm_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic        immsrc;
  logic [31:0] base;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        range_err;

  modport master (
    output in_valid, immsrc, base, imm, out_ready,
    input  in_ready, out_valid, inst, range_err
  );

  modport slave (
    input  in_valid, immsrc, base, imm, out_ready,
    output in_ready, out_valid, inst, range_err
  );
endinterface

// File: rtl/imm_encode.sv
// rtl/imm_encode.sv - two-stage valid/ready encoder scattering a signed immediate into I/S-type instruction words.
// Optional feature macro: IMM_RANGE_CHECK_EN builds range_err and the saturating err_cnt.
module imm_encode #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  imm_encode_if.slave      bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic        s1_valid_q, s1_valid_d;
  logic        s1_immsrc_q, s1_immsrc_d;
  logic [31:0] s1_base_q, s1_base_d;
  logic [31:0] s1_imm_q, s1_imm_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;

  logic        s1_advance;
  logic        in_ready_w;
  logic        in_hs;
  logic        out_hs;
  logic [31:0] enc_word;

  // S1 may move forward whenever S2 is empty or is being drained this edge.
  assign s1_advance = s1_valid_q & (~s2_valid_q | bus.out_ready);
  assign in_ready_w = ~s1_valid_q | s1_advance;
  assign in_hs      = bus.in_valid & in_ready_w;
  assign out_hs     = s2_valid_q & bus.out_ready;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = s2_valid_q;
  assign bus.inst      = inst_q;
  assign enc_cnt       = enc_cnt_q;

  // Template immediate bits are always replaced, never merged.
  always_comb begin
    enc_word = s1_base_q;
    if (!s1_immsrc_q) begin
      enc_word[31:20] = s1_imm_q[11:0];
    end else begin
      enc_word[31:25] = s1_imm_q[11:5];
      enc_word[11:7]  = s1_imm_q[4:0];
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_immsrc_d = s1_immsrc_q;
    s1_base_d   = s1_base_q;
    s1_imm_d    = s1_imm_q;
    if (in_hs) begin
      s1_valid_d  = 1'b1;
      s1_immsrc_d = bus.immsrc;
      s1_base_d   = bus.base;
      s1_imm_d    = bus.imm;
    end else if (s1_advance) begin
      s1_valid_d  = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    inst_d     = inst_q;
    if (s1_advance) begin
      s2_valid_d = 1'b1;
      inst_d     = enc_word;
    end else if (out_hs) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    enc_cnt_d = enc_cnt_q;
    if (cnt_clr) begin
      enc_cnt_d = '0;
    end else if (out_hs) begin
      enc_cnt_d = enc_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_immsrc_q <= 1'b0;
      s1_base_q   <= '0;
      s1_imm_q    <= '0;
      s2_valid_q  <= 1'b0;
      inst_q      <= '0;
      enc_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_immsrc_q <= s1_immsrc_d;
      s1_base_q   <= s1_base_d;
      s1_imm_q    <= s1_imm_d;
      s2_valid_q  <= s2_valid_d;
      inst_q      <= inst_d;
      enc_cnt_q   <= enc_cnt_d;
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic             range_q, range_d;
  logic             range_s1;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // Fits in 12 signed bits only when imm[31:11] is a pure sign extension.
  assign range_s1 = ~((&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]));

  always_comb begin
    range_d = range_q;
    if (s1_advance) begin
      range_d = range_s1;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cnt_clr) begin
      err_cnt_d = '0;
    end else if (out_hs && range_q && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      range_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      range_q   <= range_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.range_err = range_q;
  assign err_cnt       = err_cnt_q;
`else
  // Upper immediate bits only matter to the range check; truncation is silent here.
  logic unused_imm_hi;
  assign unused_imm_hi = ^s1_imm_q[31:12];

  assign bus.range_err = 1'b0;
  assign err_cnt       = '0;
`endif

endmodule
